// File: rtl/atm_session_ctrl.sv
// atm_session_ctrl: ATM session sequencer between the front panel and the account store.
// Ports: clk/rst (async, active-low); panel side card_in, card_number, pin_valid/pin,
// op_valid/op_code/amount; store side acct_balance, acct_wrong_psw in and
// acct_card_in, acct_card_number, acct_password, acct_op_done, acct_updated_balance out;
// status result_valid, result_balance, err, card_eject, card_retain, busy.
// Optional macro ATM_DAILY_LIMIT_EN enables the per-session withdraw cap (DAILY_LIMIT).
module atm_session_ctrl #(
  parameter int CARD_WIDTH     = 3,
  parameter int PASSWORD_WIDTH = 4,
  parameter int BALANCE_WIDTH  = 20,
  parameter int USERS_NUM      = 7,
  parameter int MAX_TRIES      = 3,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int DAILY_LIMIT    = 500
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      card_in,
  input  logic [CARD_WIDTH-1:0]     card_number,
  input  logic                      pin_valid,
  input  logic [PASSWORD_WIDTH-1:0] pin,
  input  logic                      op_valid,
  input  logic [1:0]                op_code,
  input  logic [BALANCE_WIDTH-1:0]  amount,
  input  logic [BALANCE_WIDTH-1:0]  acct_balance,
  input  logic                      acct_wrong_psw,
  output logic                      acct_card_in,
  output logic [CARD_WIDTH-1:0]     acct_card_number,
  output logic [PASSWORD_WIDTH-1:0] acct_password,
  output logic                      acct_op_done,
  output logic [BALANCE_WIDTH-1:0]  acct_updated_balance,
  output logic                      result_valid,
  output logic [BALANCE_WIDTH-1:0]  result_balance,
  output logic [1:0]                err,
  output logic                      card_eject,
  output logic                      card_retain,
  output logic                      busy
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int NW = $clog2(MAX_TRIES + 1);
  typedef enum logic [3:0] {
    IDLE, PIN_WAIT, CHECK1, CHECK2, MENU, EXEC, COMMIT, EJECT, RETAIN, WAIT_REMOVE
  } state_t;
  state_t state, nxt;
  logic card_q, rise, gone, timeout, last_try, insuf, over_limit, res_v, commit;
  logic [CARD_WIDTH-1:0] card_id, id_d;
  logic [1:0] op_q, err_d;
  logic [BALANCE_WIDTH-1:0] amt_q, res_b, new_bal;
  logic [BALANCE_WIDTH:0] dep_sum;
  logic [TW-1:0] timer;
  logic [NW-1:0] tries;
`ifdef ATM_DAILY_LIMIT_EN
  logic [BALANCE_WIDTH+1:0] spent, spent_sum;
  assign spent_sum  = spent + {2'b00, amt_q};
  assign over_limit = spent_sum > (BALANCE_WIDTH + 2)'(DAILY_LIMIT);
`else
  assign over_limit = 1'b0;
`endif
  assign rise     = card_in & ~card_q;
  // Level check is enough: every non-IDLE state was entered with the card present.
  assign gone     = (state != IDLE) & ~card_in;
  assign timeout  = timer == TW'(TIMEOUT_CYCLES - 1);
  assign last_try = tries + 1'b1 == NW'(MAX_TRIES);
  // acct_updated_balance doubles as the session shadow balance.
  assign insuf    = amt_q > acct_updated_balance;
  assign dep_sum  = {1'b0, acct_updated_balance} + {1'b0, amt_q};
  assign id_d     = state == IDLE ? card_number : card_id;
  always_comb begin
    nxt     = state;
    res_v   = 1'b0;
    commit  = 1'b0;
    err_d   = err;
    res_b   = result_balance;
    new_bal = acct_updated_balance;
    if (gone) nxt = IDLE;
    else
      case (state)
        IDLE:     nxt = !rise ? IDLE : card_number >= CARD_WIDTH'(USERS_NUM) ? EJECT : PIN_WAIT;
        PIN_WAIT: nxt = pin_valid ? CHECK1 : timeout ? EJECT : PIN_WAIT;
        CHECK1:   nxt = CHECK2;
        CHECK2:   nxt = !acct_wrong_psw ? MENU : last_try ? RETAIN : PIN_WAIT;
        MENU:     nxt = !op_valid ? (timeout ? EJECT : MENU) : op_code == 2'b11 ? EJECT : EXEC;
        EXEC: begin
          // Result and commit strobe are registered on leaving EXEC so both land together.
          res_v   = 1'b1;
          err_d   = op_q == 2'b01 ? (insuf ? 2'b01 : over_limit ? 2'b11 : 2'b00)
                  : op_q == 2'b10 ? {dep_sum[BALANCE_WIDTH], 1'b0} : 2'b00;
          commit  = op_q != 2'b00 && err_d == 2'b00;
          new_bal = op_q == 2'b01 ? acct_updated_balance - amt_q : dep_sum[BALANCE_WIDTH-1:0];
          res_b   = commit ? new_bal : acct_updated_balance;
          nxt     = commit ? COMMIT : MENU;
        end
        COMMIT:         nxt = MENU;
        EJECT, RETAIN:  nxt = WAIT_REMOVE;
        default:        nxt = state;
      endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                <= IDLE;
      card_q               <= 1'b0;
      card_id              <= '0;
      timer                <= '0;
      tries                <= '0;
      op_q                 <= 2'b00;
      amt_q                <= '0;
`ifdef ATM_DAILY_LIMIT_EN
      spent                <= '0;
`endif
      acct_card_in         <= 1'b0;
      acct_card_number     <= '1;
      acct_password        <= '0;
      acct_op_done         <= 1'b0;
      acct_updated_balance <= '0;
      result_valid         <= 1'b0;
      result_balance       <= '0;
      err                  <= 2'b00;
      card_eject           <= 1'b0;
      card_retain          <= 1'b0;
      busy                 <= 1'b0;
    end else begin
      state  <= nxt;
      card_q <= card_in;
      timer  <= (state == PIN_WAIT || state == MENU) && nxt == state ? timer + 1'b1 : '0;
      if (state == IDLE && nxt != IDLE) begin
        card_id <= card_number;
        tries   <= '0;
      end
      if (state == CHECK2 && !gone && acct_wrong_psw) tries <= tries + 1'b1;
      if (state == PIN_WAIT && nxt == CHECK1) acct_password <= pin;
      if (nxt == EXEC) begin
        op_q  <= op_code;
        amt_q <= amount;
      end
`ifdef ATM_DAILY_LIMIT_EN
      if (state == IDLE && nxt != IDLE) spent <= '0;
      else if (commit && op_q == 2'b01) spent <= spent_sum;
`endif
      if (state == CHECK2 && !gone) acct_updated_balance <= acct_balance;
      else if (commit) acct_updated_balance <= new_bal;
      acct_card_in     <= nxt inside {PIN_WAIT, CHECK1, CHECK2, MENU, EXEC, COMMIT};
      acct_card_number <= nxt inside {PIN_WAIT, CHECK1, CHECK2, MENU, EXEC, COMMIT} ? id_d : '1;
      acct_op_done     <= commit;
      result_valid     <= res_v;
      result_balance   <= res_b;
      err              <= err_d;
      card_eject       <= nxt == EJECT;
      card_retain      <= nxt == RETAIN;
      busy             <= nxt != IDLE;
    end
  end
endmodule

// File: tb/tb_atm_session_ctrl.sv
// tb_atm_session_ctrl: randomized self-checking bench with an account-store model and a session reference model.
module tb_atm_session_ctrl;
  localparam int TO = 1000;
  localparam int LIMIT = 500;
`ifdef ATM_DAILY_LIMIT_EN
  localparam bit LIM_EN = 1'b1;
`else
  localparam bit LIM_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0;
  logic card_in = 1'b0, pin_valid = 1'b0, op_valid = 1'b0;
  logic [2:0] card_number = '0;
  logic [3:0] pin = '0;
  logic [1:0] op_code = '0;
  logic [19:0] amount = '0;
  logic [19:0] acct_balance;
  logic acct_wrong_psw;
  logic acct_card_in, acct_op_done, result_valid, card_eject, card_retain, busy;
  logic [2:0] acct_card_number;
  logic [3:0] acct_password;
  logic [19:0] acct_updated_balance, result_balance;
  logic [1:0] err;
  int checks = 0, failures = 0;
  logic [19:0] init_bal [8];
  logic [3:0]  init_psw [8];
  logic [19:0] store_bal [8];
  int unsigned exp_bal [8];
  int unsigned spent;

  always #5 clk = ~clk;

  atm_session_ctrl dut (
    .clk(clk), .rst(rst), .card_in(card_in), .card_number(card_number),
    .pin_valid(pin_valid), .pin(pin), .op_valid(op_valid), .op_code(op_code),
    .amount(amount), .acct_balance(acct_balance), .acct_wrong_psw(acct_wrong_psw),
    .acct_card_in(acct_card_in), .acct_card_number(acct_card_number),
    .acct_password(acct_password), .acct_op_done(acct_op_done),
    .acct_updated_balance(acct_updated_balance), .result_valid(result_valid),
    .result_balance(result_balance), .err(err), .card_eject(card_eject),
    .card_retain(card_retain), .busy(busy)
  );

  // Account store: registered read, write on commit strobe.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) store_bal[i] <= init_bal[i];
      acct_balance   <= '0;
      acct_wrong_psw <= 1'b0;
    end else begin
      acct_balance   <= store_bal[acct_card_number];
      acct_wrong_psw <= acct_password != init_psw[acct_card_number];
      if (acct_op_done) store_bal[acct_card_number] <= acct_updated_balance;
    end
  end

  task automatic insert(input int c);
    @(negedge clk);
    card_in = 1'b1;
    card_number = 3'(c);
    spent = 0;
    @(negedge clk);
    checks++;
    if (c >= 7) begin
      if (card_eject !== 1'b1 || acct_card_in !== 1'b0 || busy !== 1'b1)
        $display("FAIL insert_bad card=%0d eject=%b acct_card_in=%b busy=%b want 1 0 1", c, card_eject, acct_card_in, busy);
      if (card_eject !== 1'b1 || acct_card_in !== 1'b0 || busy !== 1'b1) failures++;
    end else if (acct_card_in !== 1'b1 || acct_card_number !== 3'(c) || busy !== 1'b1 || card_eject !== 1'b0) begin
      failures++;
      $display("FAIL insert card=%0d acct_card_in=%b num=%0d busy=%b eject=%b", c, acct_card_in, acct_card_number, busy, card_eject);
    end
  endtask

  task automatic remove_card;
    card_in = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || acct_card_in !== 1'b0 || acct_card_number !== 3'b111) begin
      failures++;
      $display("FAIL remove busy=%b acct_card_in=%b num=%0d want 0 0 7", busy, acct_card_in, acct_card_number);
    end
  endtask

  task automatic enter_pin(input logic [3:0] p, input bit exp_retain);
    pin_valid = 1'b1;
    pin = p;
    @(negedge clk);
    pin_valid = 1'b0;
    checks++;
    if (acct_password !== p) begin
      failures++;
      $display("FAIL pin_latch got=%0d want=%0d", acct_password, p);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (card_retain !== exp_retain) begin
      failures++;
      $display("FAIL retain got=%b want=%b", card_retain, exp_retain);
    end
  endtask

  task automatic do_op(input logic [1:0] code, input logic [19:0] amt, input int c);
    longint cur, sum;
    logic [1:0] e;
    bit cm;
    logic [19:0] rb;
    cur = longint'(exp_bal[c]);
    e = 2'd0;
    cm = 1'b0;
    rb = 20'(cur);
    if (code == 2'd1) begin
      if (longint'(amt) > cur) e = 2'd1;
      else if (LIM_EN && longint'(spent) + longint'(amt) > LIMIT) e = 2'd3;
      else begin cm = 1'b1; rb = 20'(cur - longint'(amt)); end
    end else if (code == 2'd2) begin
      sum = cur + longint'(amt);
      if (sum > 64'hFFFFF) e = 2'd2;
      else begin cm = 1'b1; rb = 20'(sum); end
    end
    op_valid = 1'b1;
    op_code = code;
    amount = amt;
    @(negedge clk);
    op_valid = 1'b0;
    checks++;
    if (result_valid !== 1'b0) begin
      failures++;
      $display("FAIL op_early result_valid=%b want 0", result_valid);
    end
    @(negedge clk);
    checks++;
    if (result_valid !== 1'b1 || err !== e || result_balance !== rb || acct_op_done !== cm) begin
      failures++;
      $display("FAIL op code=%0d amt=%0d got rv=%b err=%0d bal=%0d done=%b want 1 %0d %0d %b",
               code, amt, result_valid, err, result_balance, acct_op_done, e, rb, cm);
    end
    if (cm) begin
      checks++;
      if (acct_updated_balance !== rb) begin
        failures++;
        $display("FAIL writeback got=%0d want=%0d", acct_updated_balance, rb);
      end
      exp_bal[c] = rb;
      if (code == 2'd1) spent += amt;
    end
    @(negedge clk);
    checks++;
    if (result_valid !== 1'b0 || acct_op_done !== 1'b0 || store_bal[c] !== 20'(exp_bal[c])) begin
      failures++;
      $display("FAIL op_after rv=%b done=%b store=%0d want 0 0 %0d", result_valid, acct_op_done, store_bal[c], exp_bal[c]);
    end
  endtask

  task automatic end_session;
    op_valid = 1'b1;
    op_code = 2'b11;
    @(negedge clk);
    op_valid = 1'b0;
    checks++;
    if (card_eject !== 1'b1) begin
      failures++;
      $display("FAIL end_eject got=%b want 1", card_eject);
    end
    remove_card();
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || acct_card_in !== 1'b0 || acct_card_number !== 3'b111 || acct_password !== 4'd0 ||
        acct_updated_balance !== 20'd0 || result_balance !== 20'd0 || err !== 2'd0 || result_valid !== 1'b0 ||
        card_eject !== 1'b0 || card_retain !== 1'b0 || acct_op_done !== 1'b0) begin
      failures++;
      $display("FAIL reset busy=%b cin=%b num=%0d pw=%0d upd=%0d rb=%0d err=%0d rv=%b ej=%b rt=%b done=%b",
               busy, acct_card_in, acct_card_number, acct_password, acct_updated_balance, result_balance,
               err, result_valid, card_eject, card_retain, acct_op_done);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_operations;
    insert(2);
    enter_pin(init_psw[2], 1'b0);
    do_op(2'd0, 20'd0, 2);
    do_op(2'd1, 20'd1200, 2);
    do_op(2'd2, 20'd1048000, 2);
    do_op(2'd1, 20'd300, 2);
    do_op(2'd0, 20'd0, 2);
    end_session();
  endtask

  task automatic test_daily_limit;
    insert(2);
    enter_pin(init_psw[2], 1'b0);
    do_op(2'd1, 20'd400, 2);
    do_op(2'd1, 20'd200, 2);
    end_session();
  endtask

  task automatic test_retain;
    insert(3);
    enter_pin(init_psw[3] ^ 4'd1, 1'b0);
    enter_pin(init_psw[3] ^ 4'd2, 1'b0);
    enter_pin(init_psw[3] ^ 4'd4, 1'b1);
    remove_card();
  endtask

  task automatic test_bad_card;
    insert(7);
    @(negedge clk);
    checks++;
    if (card_eject !== 1'b0) begin
      failures++;
      $display("FAIL eject_pulse got=%b want 0", card_eject);
    end
    remove_card();
  endtask

  task automatic test_timeout;
    int n;
    bit seen;
    insert(4);
    enter_pin(init_psw[4], 1'b0);
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < TO + 20 && !seen; i++) begin
      @(negedge clk);
      n++;
      seen = card_eject;
    end
    checks++;
    if (!seen || n < TO - 1 || n > TO + 2) begin
      failures++;
      $display("FAIL timeout seen=%b cycles=%0d want eject after %0d..%0d", seen, n, TO - 1, TO + 2);
    end
    remove_card();
  endtask

  task automatic test_remove_pin_wait;
    insert(1);
    @(negedge clk);
    remove_card();
  endtask

  task automatic test_random;
    for (int s = 0; s < 10; s++) begin
      int c, wrong;
      bit in_menu, good;
      logic [3:0] p;
      c = int'($urandom_range(0, 7));
      insert(c);
      if (c == 7) begin
        remove_card();
        continue;
      end
      wrong = 0;
      in_menu = 1'b0;
      while (!in_menu && wrong < 3) begin
        good = 1'($urandom_range(0, 1));
        p = good ? init_psw[c] : init_psw[c] ^ 4'($urandom_range(1, 15));
        if (!good) wrong++;
        enter_pin(p, !good && wrong == 3);
        in_menu = good;
      end
      if (in_menu) begin
        repeat ($urandom_range(2, 5)) begin
          logic [1:0] code;
          logic [19:0] amt;
          code = 2'($urandom_range(0, 2));
          amt = code == 2'd1 ? 20'($urandom_range(0, exp_bal[c] + 300))
              : ($urandom_range(0, 3) == 0) ? 20'hFFFFF - 20'($urandom_range(0, 2000))
              : 20'($urandom_range(0, 3000));
          do_op(code, amt, c);
        end
        end_session();
      end else remove_card();
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      init_bal[i] = 20'($urandom_range(0, 5000));
      init_psw[i] = 4'($urandom_range(0, 15));
    end
    init_bal[2] = 20'd1000;
    for (int i = 0; i < 8; i++) exp_bal[i] = init_bal[i];
    test_reset();
    test_operations();
    test_daily_limit();
    test_retain();
    test_bad_card();
    test_timeout();
    test_remove_pin_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end
endmodule

// File: doc/atm_session_ctrl.md
# atm_session_ctrl

Session sequencer between the ATM front panel and the account store. Tracks card insertion, PIN entry with a bounded retry count, and per-operation requests (balance inquiry, withdraw, deposit). It is the only block that addresses the account store: it drives the store's card-present, card number, PIN and commit strobe, and produces the updated balance to write back.

## Interface
- CARD_WIDTH, 3, card number width
- PASSWORD_WIDTH, 4, PIN width
- BALANCE_WIDTH, 20, balance/amount width
- USERS_NUM, 7, valid card numbers are 0..USERS_NUM-1; must be < 2^CARD_WIDTH
- MAX_TRIES, 3, wrong PINs before card retention
- TIMEOUT_CYCLES, 1000, idle cycles allowed in PIN_WAIT/MENU
- DAILY_LIMIT, 500, per-session withdraw cap (only with ATM_DAILY_LIMIT_EN)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- card_in  in  1  card present level
- card_number  in  CARD_WIDTH  card id, sampled on card_in rise
- pin_valid  in  1  one-cycle PIN strobe
- pin  in  PASSWORD_WIDTH  PIN, sampled with pin_valid
- op_valid  in  1  one-cycle operation strobe
- op_code  in  2  00 inquiry, 01 withdraw, 10 deposit, 11 end session
- amount  in  BALANCE_WIDTH  operand, sampled with op_valid
- acct_balance  in  BALANCE_WIDTH  balance from store
- acct_wrong_psw  in  1  PIN mismatch from store
- acct_card_in  out  1  card-present to store
- acct_card_number  out  CARD_WIDTH  store address
- acct_password  out  PASSWORD_WIDTH  PIN to store
- acct_op_done  out  1  one-cycle commit strobe
- acct_updated_balance  out  BALANCE_WIDTH  write-back value
- result_valid  out  1  one-cycle, op finished
- result_balance  out  BALANCE_WIDTH  balance after op
- err  out  2  with result_valid: 00 ok, 01 insufficient, 10 overflow, 11 limit
- card_eject, card_retain  out  1 each  one-cycle pulses
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, PIN_WAIT, CHECK1, CHECK2, MENU, EXEC, COMMIT, EJECT, RETAIN, WAIT_REMOVE.
- IDLE: acct_card_in=0, acct_card_number parked at 2^CARD_WIDTH-1 (out of range, store ignores). card_in rise: latch card_number; if >= USERS_NUM go EJECT, else PIN_WAIT, tries=0.
- acct_card_in=1 and acct_card_number=latched id in all states from PIN_WAIT through COMMIT; writes happen only via acct_op_done.
- PIN_WAIT: pin_valid -> latch to acct_password, CHECK1. CHECK1 waits one cycle (store registers). CHECK2: sample acct_wrong_psw, acct_balance into shadow. Mismatch: tries+1; tries==MAX_TRIES -> RETAIN, else PIN_WAIT. Match -> MENU.
- MENU: op_valid -> EXEC; op_code 11 -> EJECT.
- EXEC (one cycle, uses shadow balance, never acct_balance): inquiry -> result, err 00, MENU. Withdraw: amount > shadow -> err 01, no commit; else shadow-amount -> COMMIT. Deposit: BALANCE_WIDTH+1-bit sum; carry -> err 10, no commit; else COMMIT.
- COMMIT: acct_op_done=1, acct_updated_balance=new value, shadow updated, result_valid with err 00, -> MENU.
- acct_updated_balance always holds the shadow value otherwise (write-back idempotent).
- Timer: counts in PIN_WAIT/MENU, cleared on pin_valid/op_valid or state entry; reaching TIMEOUT_CYCLES -> EJECT.
- EJECT: card_eject pulse -> WAIT_REMOVE. RETAIN: card_retain pulse -> WAIT_REMOVE. WAIT_REMOVE: card_in=0 -> IDLE.
- card_in falling in any non-IDLE state -> IDLE next cycle; pending EXEC is dropped, COMMIT already issued stands.
- Strobes arriving outside PIN_WAIT/MENU are ignored.

## Timing
- Reset: state IDLE, all pulses 0, acct_card_in 0, acct_card_number all-ones, acct_password 0, acct_updated_balance 0, result_balance 0, err 00, tries 0, timer 0, busy 0.
- pin_valid to MENU/PIN_WAIT decision: 3 cycles (PIN_WAIT->CHECK1->CHECK2->next).
- op_valid to result_valid: 2 cycles for inquiry/reject (EXEC registers result), 2 cycles for commit with acct_op_done in same cycle as result_valid.
- All outputs registered.

## Configuration
- ATM_DAILY_LIMIT_EN defined: session accumulator of committed withdrawals (cleared on card_in rise); withdraw whose total would exceed DAILY_LIMIT -> err 11, no commit. Insufficient check has priority over limit.
- Undefined: no accumulator, err 11 never produced.

## Test plan
- Card 2, balance 1000, correct PIN, inquiry -> result_balance 1000, err 00, no acct_op_done.
- Withdraw 300 then inquiry -> acct_op_done with 700, second result 700.
- Withdraw 1200 from 1000 -> err 01, no acct_op_done; deposit 1048000 on 1000 -> err 10.
- Three wrong PINs -> card_retain pulse after third CHECK2, no MENU entry; card number 7 -> immediate card_eject.
- No input for TIMEOUT_CYCLES in MENU -> card_eject; card_in dropped mid-PIN_WAIT -> IDLE, busy 0 next cycle.
- With ATM_DAILY_LIMIT_EN, withdraw 400 then 200 -> second err 11; without macro, both commit.
